// File: rtl/conv_w_fetch_if.sv
// Port-A read bus to the conv weight BRAM plus the weight stream to the conv engine.
interface conv_w_fetch_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned WGT_W  = 8
);
  logic              bram_ena;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_douta;
  logic              bram_rd_vld;
  logic [WGT_W-1:0]  w_data;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;

  modport master (
    output bram_ena, bram_addra,
    input  bram_douta, bram_rd_vld,
    output w_data, w_valid, w_last,
    input  w_ready
  );

  modport slave (
    input  bram_ena, bram_addra,
    output bram_douta, bram_rd_vld,
    input  w_data, w_valid, w_last,
    output w_ready
  );
endinterface

// File: rtl/conv_w_fetch.sv
// Weight fetch sequencer: reads a run of BRAM words, buffers them and streams
// three signed 8-bit weights per word to the conv engine.
module conv_w_fetch #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned WGT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  conv_w_fetch_if.master    bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PND_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] pop_rem;
  logic              inflight;
  logic [1:0]        lane;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic [DATA_W-1:0] head;
  logic              handshake;
  logic              push;
  logic              pop;
  logic [PND_W-1:0]  pending;
  logic              can_issue;

  assign head        = mem[rd_ptr];
  assign bus.w_valid = (fifo_count != CNT_W'(0));
  assign bus.w_last  = bus.w_valid && (lane == 2'd2) && (pop_rem == ADDR_W'(1));
  assign handshake   = bus.w_valid && bus.w_ready;
  assign pop         = handshake && (lane == 2'd2);
  // Data returning for a read issued before a reset has inflight=0 and is dropped.
  assign push        = bus.bram_rd_vld && inflight;
  // Words buffered plus reads already issued whose data has not yet landed.
  assign pending     = PND_W'(fifo_count) + PND_W'(bus.bram_ena) + PND_W'(inflight);
  assign can_issue   = (pending < PND_W'(FIFO_DEPTH));

  always_comb begin
    bus.w_data = head[WGT_W-1:0];
    case (lane)
      2'd0:    bus.w_data = head[WGT_W-1:0];
      2'd1:    bus.w_data = head[2*WGT_W-1:WGT_W];
      default: bus.w_data = head[3*WGT_W-1:2*WGT_W];
    endcase
  end

  // Job sequencing, read issue and lane tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.bram_ena   <= 1'b0;
      bus.bram_addra <= '0;
      addr           <= '0;
      rem            <= '0;
      pop_rem        <= '0;
      inflight       <= 1'b0;
      lane           <= 2'd0;
    end else begin
      done         <= 1'b0;
      bus.bram_ena <= 1'b0;
      inflight     <= bus.bram_ena;
      if (handshake) lane <= (lane == 2'd2) ? 2'd0 : lane + 2'd1;
      if (pop) pop_rem <= pop_rem - ADDR_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            addr    <= base_addr;
            rem     <= num_words;
            pop_rem <= num_words;
            if (num_words != ADDR_W'(0)) begin
              state <= S_FETCH;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // Leave once the final read's enable is on the bus.
          if (rem == ADDR_W'(0)) begin
            state <= S_DRAIN;
          end else if (can_issue) begin
            bus.bram_ena   <= 1'b1;
            bus.bram_addra <= addr;
            addr           <= addr + ADDR_W'(1);
            rem            <= rem - ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (handshake && bus.w_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word buffer; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.bram_douta;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_w_fetch.sv
// Directed bench for conv_w_fetch with a 1-cycle-latency BRAM model.
module tb_conv_w_fetch;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned WGT_W      = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              busy;
  logic              done;

  conv_w_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WGT_W(WGT_W)) bus ();

  conv_w_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WGT_W(WGT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] bram_mem [4096];
  always @(posedge clk) begin
    bus.bram_rd_vld <= bus.bram_ena;
    if (bus.bram_ena) bus.bram_douta <= bram_mem[bus.bram_addra];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [WGT_W:0]    exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [WGT_W:0]    e;
  int ena_cnt, done_cnt, first_ena, first_vld, first_acc, last_acc, wlast_cyc, done_cyc;

  always @(negedge clk) begin
    if (bus.bram_ena) begin
      addr_q.push_back(bus.bram_addra);
      ena_cnt++;
      if (first_ena < 0) first_ena = cyc;
    end
    if (bus.w_valid && first_vld < 0) first_vld = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.w_valid && bus.w_ready) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (bus.w_last) wlast_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("extra_weight", 32'(bus.w_valid && bus.w_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("w_data", 32'(bus.w_data), 32'(e[WGT_W-1:0]));
        check("w_last", 32'(bus.w_last), 32'(e[WGT_W]));
      end
    end
  end

  task automatic reset_monitor();
    exp_q.delete();
    addr_q.delete();
    ena_cnt = 0; done_cnt = 0;
    first_ena = -1; first_vld = -1; first_acc = -1;
    last_acc = -1; wlast_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(i);
      w = bram_mem[a];
      for (int l = 0; l < 3; l++)
        exp_q.push_back({(i == n - 1) && (l == 2), w[l*WGT_W +: WGT_W]});
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    @(posedge clk); #1;
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  logic [ADDR_W-1:0] t3_addrs [4];
  logic [WGT_W-1:0]  held_data;
  logic              held_last;
  bit                have_held;
  int                stable_bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++)
      bram_mem[a] = {8'(a*3 + 2), 8'(a*3 + 1), 8'(a*3)};
    bram_mem[12'h010] = 24'h030201;
    bram_mem[12'h011] = 24'h060504;
    bus.w_ready = 1'b0;
    reset_monitor();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ena",   32'(bus.bram_ena), 32'd0);
    check("rst_addra", 32'(bus.bram_addra), 32'd0);
    check("rst_valid", 32'(bus.w_valid), 32'd0);
    check("rst_last",  32'(bus.w_last), 32'd0);
    check("rst_wdata", 32'(bus.w_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: two words, consumer always ready
    reset_monitor();
    bus.w_ready = 1'b1;
    exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h003);
    exp_q.push_back(9'h004); exp_q.push_back(9'h005); exp_q.push_back(9'h106);
    pulse_start(12'h010, 12'd2);
    @(negedge clk);
    check("t1_busy_high", 32'(busy), 32'd1);
    wait_done(50, "t1");
    check("t1_busy_at_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("t1_reads", 32'(ena_cnt), 32'd2);
    check("t1_addr0", 32'(addr_q[0]), 32'h010);
    check("t1_addr1", 32'(addr_q[1]), 32'h011);
    check("t1_first_latency", 32'(first_vld - first_ena), 32'd2);
    check("t1_back_to_back", 32'(last_acc - first_acc), 32'd5);
    check("t1_done_after_last", 32'(done_cyc - wlast_cyc), 32'd1);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_exp_left", 32'(exp_q.size()), 32'd0);

    // T2: zero-length job
    reset_monitor();
    pulse_start(12'h055, 12'd0);
    @(negedge clk);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t2_done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    check("t2_no_reads", 32'(ena_cnt), 32'd0);
    check("t2_done_pulses", 32'(done_cnt), 32'd1);

    // T3: address wrap
    reset_monitor();
    t3_addrs[0] = 12'hFFE; t3_addrs[1] = 12'hFFF; t3_addrs[2] = 12'h000; t3_addrs[3] = 12'h001;
    push_exp(12'hFFE, 4);
    pulse_start(12'hFFE, 12'd4);
    wait_done(100, "t3");
    repeat (2) @(negedge clk);
    check("t3_reads", 32'(ena_cnt), 32'd4);
    for (int i = 0; i < 4; i++) check("t3_addr", 32'(addr_q[i]), 32'(t3_addrs[i]));
    check("t3_exp_left", 32'(exp_q.size()), 32'd0);

    // T4: consumer stall with 8 words
    reset_monitor();
    bus.w_ready = 1'b0;
    push_exp(12'h100, 8);
    pulse_start(12'h100, 12'd8);
    have_held = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.w_valid) begin
        if (!have_held) begin
          held_data = bus.w_data; held_last = bus.w_last; have_held = 1'b1;
        end else if (bus.w_data !== held_data || bus.w_last !== held_last) begin
          stable_bad++;
        end
      end
    end
    check("t4_stall_reads_le_depth", 32'(ena_cnt <= int'(FIFO_DEPTH)), 32'd1);
    check("t4_valid_in_stall", 32'(bus.w_valid), 32'd1);
    check("t4_stable_in_stall", 32'(stable_bad), 32'd0);
    check("t4_held_first_weight", 32'(held_data), 32'h00);
    @(posedge clk); #1;
    bus.w_ready = 1'b1;
    wait_done(200, "t4");
    repeat (2) @(negedge clk);
    check("t4_reads", 32'(ena_cnt), 32'd8);
    check("t4_exp_left", 32'(exp_q.size()), 32'd0);
    check("t4_done_pulses", 32'(done_cnt), 32'd1);

    // T5: start mid-job is ignored
    reset_monitor();
    push_exp(12'h200, 3);
    pulse_start(12'h200, 12'd3);
    repeat (2) @(posedge clk);
    pulse_start(12'h300, 12'd5);
    wait_done(100, "t5");
    repeat (3) @(negedge clk);
    check("t5_reads", 32'(ena_cnt), 32'd3);
    for (int i = 0; i < 3; i++) check("t5_addr", 32'(addr_q[i]), 32'h200 + 32'(i));
    check("t5_exp_left", 32'(exp_q.size()), 32'd0);
    check("t5_done_pulses", 32'(done_cnt), 32'd1);
    check("t5_busy_after", 32'(busy), 32'd0);

    // T6: reset during FETCH with a read in flight, then a fresh job
    reset_monitor();
    bus.w_ready = 1'b0;
    pulse_start(12'h040, 12'd6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_done",  32'(done), 32'd0);
    check("t6_rst_ena",   32'(bus.bram_ena), 32'd0);
    check("t6_rst_addra", 32'(bus.bram_addra), 32'd0);
    check("t6_rst_valid", 32'(bus.w_valid), 32'd0);
    check("t6_rst_last",  32'(bus.w_last), 32'd0);
    check("t6_rst_wdata", 32'(bus.w_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    reset_monitor();
    bus.w_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_stale_dropped", 32'(bus.w_valid), 32'd0);
    push_exp(12'h020, 1);
    pulse_start(12'h020, 12'd1);
    wait_done(50, "t6");
    repeat (3) @(negedge clk);
    check("t6_reads", 32'(ena_cnt), 32'd1);
    check("t6_addr0", 32'(addr_q[0]), 32'h020);
    check("t6_exp_left", 32'(exp_q.size()), 32'd0);
    check("t6_done_pulses", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
